wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that sits directly upstream of the register file and drives its single write port (reg_write, waddr, wdata). It merges two write sources: the in-order pipeline, which has fixed priority and no backpressure, and a long-latency unit (multi-cycle multiply/load) that uses a valid/ready handshake into a one-entry holding buffer. A starvation counter asserts a one-cycle pipeline stall so that the buffered write cannot be blocked indefinitely. Pending-write status is exported so that decode can detect RAW/WAW hazards on outstanding slow results.

## Interface
- DATA_W, 16, data width; matches the register file.
- STARVE_MAX, 4, number of consecutive cycles a full buffer may wait before stall is raised; range 1..15.
- clk  in  1  clock.
- arst_n  in  1  reset; asynchronous, active-low.
- p_valid  in  1  pipeline write request this cycle.
- p_waddr  in  5  pipeline destination register.
- p_wdata  in  DATA_W  pipeline write data.
- stall  out  1  registered; upstream must freeze for this cycle and re-present the same p_* next cycle.
- m_valid  in  1  slow-unit write request.
- m_ready  out  1  high when the buffer is empty; a transfer occurs when m_valid && m_ready.
- m_waddr  in  5  slow-unit destination register.
- m_wdata  in  DATA_W  slow-unit write data.
- pend_valid  out  1  buffer holds a write not yet committed.
- pend_addr  out  5  destination of the buffered write; 0 when pend_valid=0.
- reg_write  out  1  registered write enable to the register file.
- waddr  out  5  registered write address.
- wdata  out  DATA_W  registered write data.

## Operation
- State: buffer (buf_full, buf_addr, buf_data), starve_cnt (4 bits), stall flop, output flops.
- m_ready = ~buf_full. pend_valid = buf_full. pend_addr = buf_full ? buf_addr : 0.
- An accepted m transfer with m_waddr==0 is consumed and dropped; the buffer stays empty.
- p_eff = p_valid && !stall && p_waddr!=0. A pipeline write to x0 is treated as no request.
- Per-cycle selection, priority order:
  1. p_eff: output flops load p_waddr/p_wdata with reg_write=1. If buf_full and buf_addr==p_waddr, the buffered entry is killed (the pipeline write is younger) and buf_full clears.
  2. Otherwise, if buf_full: drain the buffer into the output flops with reg_write=1, and clear buf_full.
  3. Otherwise: reg_write=0; waddr and wdata hold their previous values.
- The buffer is loaded on an accepted m transfer. Because m_ready requires an empty buffer, load and drain never coincide.
- starve_cnt: cleared when the buffer is empty or drained/killed. Otherwise it increments (saturating) each cycle the buffer stays full.
- stall is set on the next edge when buf_full && !drained && starve_cnt==STARVE_MAX-1. It clears on the edge after. During a stall cycle p_valid is ignored, so the buffer is guaranteed to drain.
- While stall=1 the block does not consume the pipeline request. Upstream holds p_*.

## Timing
- Reset: reg_write=0, waddr=0, wdata=0, stall=0, buf_full=0, starve_cnt=0. Hence m_ready=1, pend_valid=0, pend_addr=0.
- Pipeline latency: p_eff in cycle N → reg_write=1 in cycle N+1 → register updated at the end of N+1. The register file's same-cycle bypass covers reads in N+1.
- Slow-path latency: an m transfer in cycle N sets pend_valid in N+1. If uncontested, it drains in N+1 (reg_write in N+2), and m_ready returns in N+2.
- Worst-case wait for a buffered write is STARVE_MAX+1 cycles of full buffer before drain: STARVE_MAX cycles blocked, 1 stall cycle.
- Asserting reset mid-operation discards the buffered entry and any in-flight output without a write; stall drops immediately.
- Write to x0 never produces reg_write=1.

## Test plan
- Reset released, p_valid=1, p_waddr=3, p_wdata=0x1234 → next cycle reg_write=1, waddr=3, wdata=0x1234; m_ready=1 throughout.
- m transfer waddr=7, data=0xBEEF, pipeline idle → pend_valid=1, pend_addr=7 for one cycle; then reg_write=1, waddr=7, wdata=0xBEEF; m_ready low exactly one cycle.
- Buffer holds r7, p_valid=1 every cycle to r1..r9, STARVE_MAX=4 → stall=1 in the 5th full cycle; in that cycle r7 drains (reg_write with waddr=7 the following cycle); the held pipeline write lands after.
- Buffer holds r5=0xAAAA, p_valid writes r5=0x5555 → r5 written once with 0x5555; pend_valid clears; no later write of 0xAAAA.
- p_waddr=0 with p_valid=1, and an m transfer to x0 → reg_write stays 0; buffer stays empty; m_ready stays 1.
- arst_n pulsed low while buf_full=1 and stall=1 → all outputs immediately return to reset values; no write follows release.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - Write-back arbiter merging pipeline and slow-unit writes into one register-file port
module wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              p_valid,
    input  logic [4:0]        p_waddr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              stall,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [4:0]        m_waddr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              pend_valid,
    output logic [4:0]        pend_addr,
    output logic              reg_write,
    output logic [4:0]        waddr,
    output logic [DATA_W-1:0] wdata
);
    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

    logic              buf_full;
    logic [4:0]        buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [3:0]        starve_cnt;

    logic              p_eff;
    logic              m_take;
    logic              kill;
    logic              drain;
    logic              released;
    logic [3:0]        starve_cnt_d;
    logic              stall_d;

    assign m_ready    = ~buf_full;
    assign pend_valid = buf_full;
    assign pend_addr  = buf_full ? buf_addr : 5'd0;

    always_comb begin
        p_eff    = p_valid && !stall && (p_waddr != 5'd0);
        // x0 transfers are accepted so the slow unit can retire, but never buffered
        m_take   = m_valid && !buf_full && (m_waddr != 5'd0);
        kill     = p_eff && buf_full && (buf_addr == p_waddr);
        drain    = !p_eff && buf_full;
        released = kill || drain;

        starve_cnt_d = starve_cnt;
        if (!buf_full || released) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt != 4'hF) begin
            starve_cnt_d = starve_cnt + 4'd1;
        end

        stall_d = buf_full && !released && (starve_cnt == STARVE_LAST);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            reg_write <= 1'b0;
            waddr     <= 5'd0;
            wdata     <= '0;
        end else begin
            reg_write <= p_eff || buf_full;
            if (p_eff) begin
                waddr <= p_waddr;
                wdata <= p_wdata;
            end else if (buf_full) begin
                waddr <= buf_addr;
                wdata <= buf_data;
            end
        end
    end

    // Load and release are exclusive: a load needs an empty buffer, a release a full one
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            buf_full <= 1'b0;
            buf_addr <= 5'd0;
            buf_data <= '0;
        end else if (m_take) begin
            buf_full <= 1'b1;
            buf_addr <= m_waddr;
            buf_data <= m_wdata;
        end else if (released) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            starve_cnt <= 4'd0;
            stall      <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_d;
            stall      <= stall_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - Self-checking bench for wb_arbiter: directed vector table, corner sequences, random vs model
module tb_wb_arbiter;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 4;

    logic              clk;
    logic              arst_n;
    logic              p_valid;
    logic [4:0]        p_waddr;
    logic [DATA_W-1:0] p_wdata;
    logic              stall;
    logic              m_valid;
    logic              m_ready;
    logic [4:0]        m_waddr;
    logic [DATA_W-1:0] m_wdata;
    logic              pend_valid;
    logic [4:0]        pend_addr;
    logic              reg_write;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;

    wb_arbiter #(.DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .arst_n(arst_n),
        .p_valid(p_valid), .p_waddr(p_waddr), .p_wdata(p_wdata), .stall(stall),
        .m_valid(m_valid), .m_ready(m_ready), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .pend_valid(pend_valid), .pend_addr(pend_addr),
        .reg_write(reg_write), .waddr(waddr), .wdata(wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: one optional pending entry plus how long it has been passed over
    bit              e_pend;
    bit [4:0]        e_paddr;
    bit [DATA_W-1:0] e_pdata;
    int              e_wait;
    bit              e_stall;
    bit              e_rw;
    bit [4:0]        e_wa;
    bit [DATA_W-1:0] e_wd;
    bit [DATA_W-1:0] exp_rf [32];
    bit [DATA_W-1:0] dut_rf [32];

    typedef struct {
        bit              pv;
        bit [4:0]        pa;
        bit [15:0]       pd;
        bit              mv;
        bit [4:0]        ma;
        bit [15:0]       md;
        bit              rw;
        bit [4:0]        wa;
        bit [15:0]       wd;
        bit              st;
        bit              mr;
        bit              pendv;
        bit [4:0]        penda;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        e_pend  = 0;
        e_paddr = 0;
        e_pdata = 0;
        e_wait  = 0;
        e_stall = 0;
        e_rw    = 0;
        e_wa    = 0;
        e_wd    = 0;
    endtask

    task automatic model_step();
        bit was_pend;
        bit p_req;
        bit consumed;
        bit nxt_stall;
        was_pend  = e_pend;
        p_req     = p_valid && !e_stall && (p_waddr != 5'd0);
        consumed  = 0;
        nxt_stall = 0;
        e_rw      = 0;
        if (p_req) begin
            e_rw = 1; e_wa = p_waddr; e_wd = p_wdata;
            if (was_pend && e_paddr == p_waddr) consumed = 1;
        end else if (was_pend) begin
            e_rw = 1; e_wa = e_paddr; e_wd = e_pdata;
            consumed = 1;
        end
        if (e_rw) exp_rf[e_wa] = e_wd;
        if (was_pend && !consumed) begin
            e_wait++;
            nxt_stall = (e_wait == STARVE_MAX);
        end else begin
            e_wait = 0;
        end
        if (consumed) e_pend = 0;
        if (!was_pend && m_valid && m_waddr != 5'd0) begin
            e_pend = 1; e_paddr = m_waddr; e_pdata = m_wdata; e_wait = 0;
        end
        e_stall = nxt_stall;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_reg_write"}, 32'(reg_write), 32'(e_rw));
        chk({tag, "_waddr"}, 32'(waddr), 32'(e_wa));
        chk({tag, "_wdata"}, 32'(wdata), 32'(e_wd));
        chk({tag, "_stall"}, 32'(stall), 32'(e_stall));
        chk({tag, "_m_ready"}, 32'(m_ready), 32'(!e_pend));
        chk({tag, "_pend_valid"}, 32'(pend_valid), 32'(e_pend));
        chk({tag, "_pend_addr"}, 32'(pend_addr), e_pend ? 32'(e_paddr) : 32'd0);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        if (reg_write === 1'b1) dut_rf[waddr] = wdata;
        check_model(tag);
    endtask

    task automatic set_in(input bit pv, input bit [4:0] pa, input bit [15:0] pd,
                          input bit mv, input bit [4:0] ma, input bit [15:0] md);
        p_valid = pv; p_waddr = pa; p_wdata = pd;
        m_valid = mv; m_waddr = ma; m_wdata = md;
    endtask

    initial begin
        //        pv pa  pd       mv ma  md       rw wa  wd       st mr pv pa
        tbl[0]  = '{1, 3, 16'h1234, 0, 0, 16'h0000, 1, 3, 16'h1234, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 3, 16'h1234, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 16'h0000, 1, 7, 16'hBEEF, 0, 3, 16'h1234, 0, 0, 1, 7};
        tbl[3]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 16'hBEEF, 0, 1, 0, 0};
        tbl[4]  = '{1, 0, 16'hDEAD, 1, 0, 16'h1111, 0, 7, 16'hBEEF, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 16'h0000, 1, 5, 16'hAAAA, 0, 7, 16'hBEEF, 0, 0, 1, 5};
        tbl[6]  = '{1, 5, 16'h5555, 0, 0, 16'h0000, 1, 5, 16'h5555, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 5, 16'h5555, 0, 1, 0, 0};
        tbl[8]  = '{1, 1, 16'h0001, 1, 7, 16'h7777, 1, 1, 16'h0001, 0, 0, 1, 7};
        tbl[9]  = '{1, 2, 16'h0002, 0, 0, 16'h0000, 1, 2, 16'h0002, 0, 0, 1, 7};
        tbl[10] = '{1, 3, 16'h0003, 0, 0, 16'h0000, 1, 3, 16'h0003, 0, 0, 1, 7};
        tbl[11] = '{1, 4, 16'h0004, 0, 0, 16'h0000, 1, 4, 16'h0004, 0, 0, 1, 7};
        tbl[12] = '{1, 5, 16'h0005, 0, 0, 16'h0000, 1, 5, 16'h0005, 1, 0, 1, 7};
        tbl[13] = '{1, 6, 16'h0006, 0, 0, 16'h0000, 1, 7, 16'h7777, 0, 1, 0, 0};
        tbl[14] = '{1, 6, 16'h0006, 0, 0, 16'h0000, 1, 6, 16'h0006, 0, 1, 0, 0};
        tbl[15] = '{1, 7, 16'h0007, 0, 0, 16'h0000, 1, 7, 16'h0007, 0, 1, 0, 0};
        tbl[16] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 7, 16'h0007, 0, 1, 0, 0};

        for (int r = 0; r < 32; r++) begin
            exp_rf[r] = '0;
            dut_rf[r] = '0;
        end
        set_in(0, 0, 0, 0, 0, 0);
        arst_n = 1'b1;
        #3 arst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_model("reset");
        arst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].pv, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md);
            tick($sformatf("tbl%0d_model", i));
            chk($sformatf("vec%0d_reg_write", i), 32'(reg_write), 32'(tbl[i].rw));
            chk($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(tbl[i].wa));
            chk($sformatf("vec%0d_wdata", i), 32'(wdata), 32'(tbl[i].wd));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].st));
            chk($sformatf("vec%0d_m_ready", i), 32'(m_ready), 32'(tbl[i].mr));
            chk($sformatf("vec%0d_pend_valid", i), 32'(pend_valid), 32'(tbl[i].pendv));
            chk($sformatf("vec%0d_pend_addr", i), 32'(pend_addr), 32'(tbl[i].penda));
        end

        // Starve a buffered r9 until stall rises, then pull reset mid-flight
        set_in(1, 1, 16'h0101, 1, 9, 16'h9999);
        tick("rst_seq_load");
        for (int k = 2; k <= 5; k++) begin
            set_in(1, 5'(k), 16'(k), 0, 0, 0);
            tick($sformatf("rst_seq_block%0d", k));
        end
        chk("pre_reset_stall", 32'(stall), 32'd1);
        chk("pre_reset_pend_valid", 32'(pend_valid), 32'd1);
        chk("pre_reset_pend_addr", 32'(pend_addr), 32'd9);
        arst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("rst_held");
        set_in(0, 0, 0, 0, 0, 0);
        arst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick($sformatf("post_rst%0d", k));

        for (int c = 0; c < 1500; c++) begin
            if (!e_stall) begin
                p_valid = ($urandom_range(0, 9) < 7);
                p_waddr = 5'($urandom_range(0, 7));
                p_wdata = 16'($urandom);
            end
            m_valid = ($urandom_range(0, 9) < 4);
            m_waddr = 5'($urandom_range(0, 7));
            m_wdata = 16'($urandom);
            tick("rand");
        end
        set_in(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick("drain_tail");

        for (int r = 1; r < 32; r++) begin
            chk($sformatf("rf_x%0d", r), 32'(dut_rf[r]), 32'(exp_rf[r]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
